// File: rtl/lsu_pkg.sv
// Shared types and Funct3 decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved encodings (011, 110, 111) collapse onto the word size.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) ? SZ_WORD : f3[1:0];
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return f3[2] && (f3_size(f3) != SZ_WORD);
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Load formatter: picks the byte/half lane out of the read word and extends it.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        uns;

  always_comb begin
    lane_b = rdata[{byte_off, 3'b000} +: 8];
    lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
    uns    = f3_unsigned(funct3);
    case (f3_size(funct3))
      SZ_BYTE: data = {{24{~uns & lane_b[7]}}, lane_b};
      SZ_HALF: data = {{16{~uns & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus access per instruction, IDLE -> BUSY -> DONE.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for an aligned load/store; latches the request
//   BUSY  | DataReq held with stable bus outputs until DataAck
//   DONE  | one cycle with Stall released; result visible on LoadResult
module lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LoadEn,
  input  logic        StoreEn,
  input  logic [2:0]  Funct3,
  input  logic [31:0] IEUAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] LoadResult,
  output logic        Stall,
  output logic        Misaligned,
  output logic        BusErr,
  output logic        DataReq,
  output logic        DataWE,
  output logic [31:0] DataAdr,
  output logic [31:0] DataWData,
  output logic [3:0]  DataByteEn,
  input  logic        DataAck,
  input  logic [31:0] DataRData
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  lsu_state_e  state_q, state_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_result_q, load_result_d;
  logic [31:0] fmt_data;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_mis;

`ifdef LSU_TIMEOUT_EN
  localparam int WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             bus_err_q, bus_err_d;
`endif

  lsu_fmt u_fmt (
    .funct3   (funct3_q),
    .byte_off (off_q),
    .rdata    (DataRData),
    .data     (fmt_data)
  );

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = WriteData;
    req_mis   = |IEUAdr[1:0];
    case (f3_size(Funct3))
      SZ_BYTE: begin
        req_be    = 4'b0001 << IEUAdr[1:0];
        req_wdata = {4{WriteData[7:0]}};
        req_mis   = 1'b0;
      end
      SZ_HALF: begin
        req_be    = IEUAdr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{WriteData[15:0]}};
        req_mis   = IEUAdr[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    load_result_d = load_result_q;
    Stall         = 1'b0;
    Misaligned    = 1'b0;
`ifdef LSU_TIMEOUT_EN
    wait_d        = wait_q;
    bus_err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!reset && (LoadEn || StoreEn)) begin
          if (req_mis) begin
            Misaligned = 1'b1;
          end else begin
            Stall    = 1'b1;
            state_d  = ST_BUSY;
            adr_d    = IEUAdr[31:2];
            wdata_d  = req_wdata;
            be_d     = req_be;
            we_d     = StoreEn && !LoadEn;
            funct3_d = Funct3;
            off_d    = IEUAdr[1:0];
`ifdef LSU_TIMEOUT_EN
            wait_d   = WaitW'(MAX_WAIT - 1);
`endif
          end
        end
      end
      ST_BUSY: begin
        Stall = 1'b1;
        if (DataAck) begin
          state_d = ST_DONE;
          if (!we_q) load_result_d = fmt_data;
        end
`ifdef LSU_TIMEOUT_EN
        else if (wait_q == '0) begin
          state_d       = ST_DONE;
          load_result_d = '0;
          bus_err_d     = 1'b1;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      adr_q         <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      load_result_q <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_q        <= '0;
      bus_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      adr_q         <= adr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      load_result_q <= load_result_d;
`ifdef LSU_TIMEOUT_EN
      wait_q        <= wait_d;
      bus_err_q     <= bus_err_d;
`endif
    end
  end

`ifdef LSU_TIMEOUT_EN
  assign BusErr = bus_err_q;
`else
  assign BusErr = 1'b0;
`endif

  assign DataReq    = (state_q == ST_BUSY);
  assign DataWE     = DataReq && we_q;
  assign DataByteEn = DataReq ? be_q : 4'b0000;
  assign DataAdr    = {adr_q, 2'b00};
  assign DataWData  = wdata_q;
  assign LoadResult = load_result_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected LoadResult values go through a scoreboard queue.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        LoadEn, StoreEn;
  logic [2:0]  Funct3;
  logic [31:0] IEUAdr, WriteData;
  logic [31:0] LoadResult;
  logic        Stall, Misaligned, BusErr;
  logic        DataReq, DataWE;
  logic [31:0] DataAdr, DataWData;
  logic [3:0]  DataByteEn;
  logic        DataAck;
  logic [31:0] DataRData;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'h0;

  lsu #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .LoadEn     (LoadEn),
    .StoreEn    (StoreEn),
    .Funct3     (Funct3),
    .IEUAdr     (IEUAdr),
    .WriteData  (WriteData),
    .LoadResult (LoadResult),
    .Stall      (Stall),
    .Misaligned (Misaligned),
    .BusErr     (BusErr),
    .DataReq    (DataReq),
    .DataWE     (DataWE),
    .DataAdr    (DataAdr),
    .DataWData  (DataWData),
    .DataByteEn (DataByteEn),
    .DataAck    (DataAck),
    .DataRData  (DataRData)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; LoadEn = 0; StoreEn = 0; Funct3 = 0; IEUAdr = 0;
    WriteData = 0; DataAck = 0; DataRData = 0;
    cyc(); cyc();
    checks++;
    if ({LoadResult, DataReq, DataWE, DataByteEn, BusErr, Stall} !== {32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b%b%b%b%b exp=0", LoadResult, DataReq, DataWE, DataByteEn, BusErr, Stall);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (DataReq !== 1'b0 || LoadResult !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b/%h exp=0/0", DataReq, LoadResult);
    end
  endtask

  task automatic do_load(input string nm, input logic [31:0] adr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] expv,
                         input logic both, input int waits);
    logic [31:0] e;
    exp_q.push_back(expv);
    last_load = expv;
    LoadEn = 1; StoreEn = both; IEUAdr = adr; Funct3 = f3;
    #1;
    checks++;
    if (Stall !== 1'b1 || Misaligned !== 1'b0) begin
      failures++;
      $display("FAIL %s.req got=stall%b mis%b exp=stall1 mis0", nm, Stall, Misaligned);
    end
    cyc();
    LoadEn = 0; StoreEn = 0; IEUAdr = $urandom; Funct3 = 3'($urandom);
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (DataReq !== 1'b1 || DataWE !== 1'b0 || Stall !== 1'b1 || DataAdr !== {adr[31:2], 2'b00}) begin
        failures++;
        $display("FAIL %s.busy got=req%b we%b stall%b adr%h exp=req1 we0 stall1 adr%h",
                 nm, DataReq, DataWE, Stall, DataAdr, {adr[31:2], 2'b00});
      end
      if (i == waits) begin
        DataAck = 1; DataRData = rdata;
      end else begin
        DataRData = $urandom;
      end
      cyc();
    end
    DataAck = 0; DataRData = $urandom;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    checks++;
    if (Stall !== 1'b0 || DataReq !== 1'b0 || LoadResult !== e) begin
      failures++;
      $display("FAIL %s.done got=stall%b req%b res%h exp=stall0 req0 res%h", nm, Stall, DataReq, LoadResult, e);
    end
    cyc();
  endtask

  task automatic do_store(input string nm, input logic [31:0] adr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input int waits);
    logic [31:0] e;
    exp_q.push_back(last_load);
    StoreEn = 1; LoadEn = 0; IEUAdr = adr; Funct3 = f3; WriteData = wd;
    #1;
    checks++;
    if (Stall !== 1'b1 || Misaligned !== 1'b0) begin
      failures++;
      $display("FAIL %s.req got=stall%b mis%b exp=stall1 mis0", nm, Stall, Misaligned);
    end
    cyc();
    StoreEn = 0; IEUAdr = $urandom; WriteData = $urandom;
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (DataReq !== 1'b1 || DataWE !== 1'b1 || DataAdr !== {adr[31:2], 2'b00} ||
          DataByteEn !== ebe || DataWData !== ewd || Stall !== 1'b1) begin
        failures++;
        $display("FAIL %s.bus got=req%b we%b adr%h be%b wd%h exp=req1 we1 adr%h be%b wd%h",
                 nm, DataReq, DataWE, DataAdr, DataByteEn, DataWData, {adr[31:2], 2'b00}, ebe, ewd);
      end
      if (i == waits) DataAck = 1;
      cyc();
    end
    DataAck = 0;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    checks++;
    if (Stall !== 1'b0 || DataReq !== 1'b0 || LoadResult !== e) begin
      failures++;
      $display("FAIL %s.done got=stall%b req%b res%h exp=stall0 req0 res%h", nm, Stall, DataReq, LoadResult, e);
    end
    cyc();
  endtask

  task automatic test_loads();
    do_load("lw",      32'h100, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    do_load("lb_neg",  32'h103, 3'b000, 32'h80FFFFFF, 32'hFFFFFF80, 0, 0);
    do_load("lbu",     32'h103, 3'b100, 32'h80FFFFFF, 32'h00000080, 0, 1);
    do_load("lb_pos",  32'h101, 3'b000, 32'h00007F00, 32'h0000007F, 0, 0);
    do_load("lbu_b2",  32'h102, 3'b100, 32'h00A50000, 32'h000000A5, 0, 2);
    do_load("lh_neg",  32'h102, 3'b001, 32'h80011234, 32'hFFFF8001, 0, 0);
    do_load("lh_pos",  32'h200, 3'b001, 32'h80007FFF, 32'h00007FFF, 0, 0);
    do_load("lhu_lo",  32'h100, 3'b101, 32'h1234F00D, 32'h0000F00D, 0, 0);
    do_load("lhu_hi",  32'h102, 3'b101, 32'hABCD0000, 32'h0000ABCD, 0, 3);
    do_load("rsv011",  32'h104, 3'b011, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    do_load("rsv110",  32'h108, 3'b110, 32'h89ABCDEF, 32'h89ABCDEF, 0, 0);
  endtask

  task automatic test_stores();
    do_store("sh_hi",  32'h202, 3'b001, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 0);
    do_store("sh_lo",  32'h400, 3'b001, 32'h55667788, 4'b0011, 32'h77887788, 1);
    do_store("sb_b0",  32'h300, 3'b000, 32'h000000A7, 4'b0001, 32'hA7A7A7A7, 0);
    do_store("sb_b1",  32'h301, 3'b000, 32'hFFFFFF3C, 4'b0010, 32'h3C3C3C3C, 0);
    do_store("sb_b3",  32'h303, 3'b000, 32'h12345691, 4'b1000, 32'h91919191, 2);
    do_store("sw",     32'h504, 3'b010, 32'h11223344, 4'b1111, 32'h11223344, 0);
    do_store("rsv111", 32'h010, 3'b111, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 0);
  endtask

  task automatic test_both_enables();
    do_load("both_en", 32'h0F0, 3'b010, 32'h600DCAFE, 32'h600DCAFE, 1, 0);
  endtask

  task automatic test_misaligned();
    logic [31:0] adrs [5] = '{32'h101, 32'h102, 32'h103, 32'h201, 32'h203};
    logic [2:0]  f3s  [5] = '{3'b010, 3'b010, 3'b001, 3'b101, 3'b010};
    logic        sts  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      LoadEn = ~sts[i]; StoreEn = sts[i]; IEUAdr = adrs[i]; Funct3 = f3s[i];
      #1;
      checks++;
      if (Misaligned !== 1'b1 || Stall !== 1'b0) begin
        failures++;
        $display("FAIL mis%0d.flag got=mis%b stall%b exp=mis1 stall0", i, Misaligned, Stall);
      end
      cyc();
      checks++;
      if (DataReq !== 1'b0 || DataWE !== 1'b0 || Stall !== 1'b0) begin
        failures++;
        $display("FAIL mis%0d.nobus got=req%b we%b stall%b exp=0", i, DataReq, DataWE, Stall);
      end
      LoadEn = 0; StoreEn = 0;
      #1;
    end
    checks++;
    if (LoadResult !== last_load) begin
      failures++;
      $display("FAIL mis.result got=%h exp=%h", LoadResult, last_load);
    end
  endtask

  task automatic test_done_ignores_enables();
    logic [31:0] e;
    exp_q.push_back(32'h0000FFEE);
    last_load = 32'h0000FFEE;
    LoadEn = 1; IEUAdr = 32'h0A2; Funct3 = 3'b101;
    cyc();
    DataAck = 1; DataRData = 32'hFFEE0000;
    cyc();
    DataAck = 0;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    checks++;
    if (Stall !== 1'b0 || DataReq !== 1'b0 || LoadResult !== e) begin
      failures++;
      $display("FAIL done_ign.done got=stall%b req%b res%h exp=stall0 req0 res%h", Stall, DataReq, LoadResult, e);
    end
    cyc();
    checks++;
    if (Stall !== 1'b1 || DataReq !== 1'b0) begin
      failures++;
      $display("FAIL done_ign.idle got=stall%b req%b exp=stall1 req0", Stall, DataReq);
    end
    LoadEn = 0;
    #1;
  endtask

  task automatic test_timeout();
    LoadEn = 1; StoreEn = 0; IEUAdr = 32'h040; Funct3 = 3'b010;
    cyc();
    LoadEn = 0;
`ifdef LSU_TIMEOUT_EN
    begin
      int busy_cycles = 0;
      logic seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (BusErr === 1'b1) seen = 1'b1;
        else begin
          if (DataReq === 1'b1) busy_cycles++;
          cyc();
        end
      end
      checks++;
      if (!seen || busy_cycles != 15 || LoadResult !== 32'h0 || Stall !== 1'b0) begin
        failures++;
        $display("FAIL timeout.buserr got=seen%b busy%0d res%h stall%b exp=seen1 busy15 res0 stall0",
                 seen, busy_cycles, LoadResult, Stall);
      end
      cyc();
      checks++;
      if (BusErr !== 1'b0) begin
        failures++;
        $display("FAIL timeout.pulse got=%b exp=0", BusErr);
      end
      last_load = 32'h0;
    end
`else
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (Stall !== 1'b1 || DataReq !== 1'b1 || BusErr !== 1'b0) begin
        failures++;
        $display("FAIL nowait.c%0d got=stall%b req%b err%b exp=stall1 req1 err0", i, Stall, DataReq, BusErr);
      end
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    last_load = 32'h0;
    checks++;
    if (DataReq !== 1'b0 || LoadResult !== 32'h0) begin
      failures++;
      $display("FAIL nowait.recover got=req%b res%h exp=req0 res0", DataReq, LoadResult);
    end
`endif
  endtask

  task automatic test_reset_in_busy();
    do_load("pre_rst", 32'h080, 3'b010, 32'h13572468, 32'h13572468, 0, 0);
    LoadEn = 1; IEUAdr = 32'h084; Funct3 = 3'b010;
    cyc();
    LoadEn = 0;
    cyc();
    checks++;
    if (DataReq !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy.busy2 got=%b exp=1", DataReq);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    DataAck = 1; DataRData = 32'h55555555;
    checks++;
    if (DataReq !== 1'b0 || LoadResult !== 32'h0) begin
      failures++;
      $display("FAIL rst_busy.drop got=req%b res%h exp=req0 res0", DataReq, LoadResult);
    end
    cyc();
    DataAck = 0;
    cyc();
    checks++;
    if (DataReq !== 1'b0 || LoadResult !== 32'h0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy.late_ack got=req%b res%h stall%b exp=req0 res0 stall0", DataReq, LoadResult, Stall);
    end
    last_load = 32'h0;
  endtask

  task automatic test_back_to_back();
    do_load("b2b_lw",  32'h900, 3'b010, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
    do_store("b2b_sb", 32'h902, 3'b000, 32'h000000C3, 4'b0100, 32'hC3C3C3C3, 0);
    do_load("b2b_lb",  32'h902, 3'b000, 32'h00C30000, 32'hFFFFFFC3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_both_enables();
    test_misaligned();
    test_done_ignores_enables();
    test_back_to_back();
    test_timeout();
    test_reset_in_busy();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the number of BUSY cycles without DataAck before a bus error (used only when LSU_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port LoadEn  in  1  current instruction is a load.
REQ-005 SHALL have port StoreEn  in  1  current instruction is a store.
REQ-006 SHALL have port Funct3  in  3  access size and signedness (Instr[14:12]).
REQ-007 SHALL have port IEUAdr  in  32  byte address from the ALU.
REQ-008 SHALL have port WriteData  in  32  store data (rs2).
REQ-009 SHALL have port LoadResult  out  32  registered, extended load data.
REQ-010 SHALL have port Stall  out  1  hold PC and suppress the register write.
REQ-011 SHALL have port Misaligned  out  1  alignment fault; combinational; no bus access is made.
REQ-012 SHALL have port BusErr  out  1  one-cycle timeout pulse.
REQ-013 SHALL have ports DataReq out 1, DataWE out 1, DataAdr out 32 (word-aligned), DataWData out 32, DataByteEn out 4, DataAck in 1 and DataRData in 32, forming the memory bus.

Function
REQ-014 SHALL implement the FSM IDLE->BUSY->DONE->IDLE.
REQ-015 In IDLE with an aligned access: latch word address, lane data, byte enables, the load/store flag and Funct3; go to BUSY; drive Stall=1.
REQ-016 In BUSY: drive DataReq=1 with all bus outputs held stable until the cycle DataAck=1; drive Stall=1.
REQ-017 In BUSY with DataAck=1: go to DONE; for a load, register the extended DataRData into LoadResult.
REQ-018 In DONE: drive Stall=0 for exactly one cycle; ignore LoadEn/StoreEn; go to IDLE unconditionally.
REQ-019 Minimum latency SHALL be 3 cycles (request, BUSY with immediate ack, DONE).
REQ-020 Load decode: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half lane selected by IEUAdr[1:0]; sign or zero extension per Funct3.
REQ-021 Store decode: 000 SB, 001 SH, 010 SW; DataWData replicates byte x4 or half x2; DataByteEn is one-hot byte, 0011/1100 half, 1111 word.
REQ-022 Reserved Funct3 values (011, 110, 111) SHALL be treated as word accesses.
REQ-023 Misaligned SHALL be 1 in IDLE for a half access with IEUAdr[0]=1 or a word access with IEUAdr[1:0]!=0; the FSM stays in IDLE with Stall=0.
REQ-024 LoadEn and StoreEn both 1 SHALL be treated as a load.
REQ-025 LoadResult SHALL hold its value until the next load completes; stores SHALL leave it unchanged.

Reset
REQ-026 Reset SHALL force IDLE, LoadResult=0, DataReq=0, DataWE=0, DataByteEn=0, BusErr=0, Stall=0 and clear the wait counter.
REQ-027 Reset asserted in BUSY SHALL drop DataReq in the following cycle; a late DataAck SHALL then be ignored.

Configuration
REQ-028 With LSU_TIMEOUT_EN defined: a counter runs in BUSY; on reaching MAX_WAIT without ack, BusErr pulses, LoadResult=0, and the FSM goes to DONE.
REQ-029 Without LSU_TIMEOUT_EN: BUSY waits indefinitely; BusErr SHALL be tied to 0 and no counter SHALL be instantiated.

Structure
REQ-030 Package lsu_pkg SHALL hold the state enum and the Funct3 size/sign constants.
REQ-031 Sub-module lsu_fmt SHALL do combinational lane extraction and extension; byte-enable and store replication logic SHALL stay in lsu.

Verification
REQ-032 LW at 0x100, DataRData=0xDEADBEEF, ack in first BUSY cycle -> Stall 1,1,0; LoadResult=0xDEADBEEF in DONE.
REQ-033 LB at 0x103, DataRData=0x80FFFFFF -> LoadResult=0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-034 SH at 0x202, WriteData=0x1234ABCD -> DataAdr=0x200, DataByteEn=1100, DataWData=0xABCDABCD, DataWE=1.
REQ-035 LW at 0x101 -> Misaligned=1, DataReq stays 0, Stall=0.
REQ-036 LSU_TIMEOUT_EN with MAX_WAIT=15 and no ack -> BusErr pulses after 15 BUSY cycles, LoadResult=0; without the macro, Stall stays 1.
REQ-037 Reset in the 2nd BUSY cycle, then ack one cycle later -> DataReq=0 and LoadResult=0 with no capture.
